stream_upsize_arb: RTL and testbench
====================================

STREAM_UPSIZE_ARB -- requirements
Module: stream_upsize_arb

Interface
REQ-001 Parameter T_DATA_WIDTH, default 1: width of one narrow beat; SHALL match the downstream stream_upsize T_DATA_WIDTH.
REQ-002 Parameter N_SRC, default 4: number of requesting sources; legal range 2..16.
REQ-003 Localparam ID_W = $clog2(N_SRC).
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 s_data_i  input  N_SRC*T_DATA_WIDTH  source i data at bits [i*T_DATA_WIDTH +: T_DATA_WIDTH].
REQ-007 s_last_i  input  N_SRC  per-source end-of-packet flag.
REQ-008 s_valid_i  input  N_SRC  per-source beat valid.
REQ-009 s_ready_o  output  N_SRC  per-source beat accept.
REQ-010 m_data_o  output  T_DATA_WIDTH  beat to stream_upsize s_data_i.
REQ-011 m_last_o  output  1  end of packet, to stream_upsize s_last_i.
REQ-012 m_valid_o  output  1  beat valid, to stream_upsize s_valid_i.
REQ-013 m_ready_i  input  1  from stream_upsize s_ready_o.
REQ-014 m_id_o  output  ID_W  index of the source that produced the current m_ beat.
REQ-015 pkt_cnt_o  output  16  count of packets fully delivered on m_.

Function
REQ-016 Beat transfer on any port SHALL occur only on a cycle where valid and ready are both 1.
REQ-017 Arbitration SHALL be packet-granular: once a source is granted, no other source is served until that source's beat with s_last_i=1 is accepted.
REQ-018 FSM states: IDLE, BUSY.
REQ-019 IDLE: s_ready_o all 0; if any s_valid_i bit is 1, grant SHALL go to the first set bit searching upward from rr_ptr with wrap at N_SRC; grant registered, next state BUSY.
REQ-020 IDLE with no s_valid_i bit set: stay IDLE, grant and rr_ptr unchanged.
REQ-021 BUSY: s_ready_o[grant] = (!m_valid_o || m_ready_i); all other s_ready_o bits 0.
REQ-022 BUSY, beat accepted with s_last_i[grant]=1: next state IDLE, rr_ptr <= (grant+1) mod N_SRC.
REQ-023 BUSY, s_valid_i[grant] deasserted mid-packet: grant held indefinitely; no timeout, no preemption.
REQ-024 Output register: on accepted beat, m_data_o/m_last_o/m_id_o load the granted source's data/last/index and m_valid_o <= 1; else if m_ready_i then m_valid_o <= 0.
REQ-025 Latency: beat accepted on cycle N appears on m_ at cycle N+1; first beat of a packet is accepted no earlier than 1 cycle after its s_valid_i is sampled in IDLE.
REQ-026 Throughput: 1 beat/cycle within a packet when m_ready_i held 1; exactly one idle arbitration cycle between packets.
REQ-027 m_ outputs SHALL hold stable while m_valid_o=1 and m_ready_i=0.
REQ-028 pkt_cnt_o SHALL increment by 1 on each cycle with m_valid_o && m_ready_i && m_last_o; wraps 0xFFFF -> 0x0000.
REQ-029 Single-beat packets (s_last_i=1 on first beat) SHALL be legal: one beat, then IDLE.
REQ-030 Simultaneous requests from all sources with continuous traffic SHALL be served in order rr_ptr, rr_ptr+1, ... (strict round-robin, no starvation).

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, rr_ptr 0, grant 0, s_ready_o 0, m_valid_o 0, m_last_o 0, m_data_o 0, m_id_o 0, pkt_cnt_o 0.
REQ-032 Reset asserted mid-packet SHALL discard the in-flight packet and register contents; after release, arbitration restarts from source 0.
REQ-033 First grant after reset release SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-034 T_DATA_WIDTH=8, N_SRC=4, m_ready_i=1; only src2 sends 3 beats 0x11,0x22,0x33(last) -> m_ carries 0x11,0x22,0x33 on consecutive cycles, m_id_o=2, m_last_o only on 0x33, pkt_cnt_o=1.
REQ-035 All 4 sources hold valid with 2-beat packets, rr_ptr=0 -> grant order 0,1,2,3,0; one IDLE cycle between packets; pkt_cnt_o=5 after fifth packet.
REQ-036 src1 mid-packet, m_ready_i=0 for 4 cycles -> m_data_o/m_last_o/m_id_o stable, s_ready_o[1]=0 while m_valid_o=1, no beat lost or duplicated.
REQ-037 src0 granted, src3 valid, src0 drops valid for 5 cycles mid-packet -> s_ready_o[3] stays 0; src0 packet completes before src3 granted.
REQ-038 Reset asserted during src2 beat 2 of 4 -> all outputs 0 within the reset; after release with src1 and src2 valid, src1 granted first (rr_ptr=0).
REQ-039 Drive 65536 single-beat packets -> pkt_cnt_o wraps to 0x0000.

Source files
------------

// File: rtl/stream_upsize_arb.sv
// stream_upsize_arb: packet-granular round-robin arbiter that funnels
// N_SRC narrow valid/ready streams into one registered stream for stream_upsize.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_data_i            N_SRC packed beats, source i at [i*T_DATA_WIDTH +: T_DATA_WIDTH]
//   s_last_i/s_valid_i  per-source end-of-packet and beat-valid flags
//   s_ready_o           per-source accept; only the granted source can see a 1
//   m_data_o/m_last_o   registered output beat and end-of-packet flag
//   m_valid_o/m_ready_i output handshake
//   m_id_o              index of the source that produced the current m_ beat
//   pkt_cnt_o           wrapping count of packets fully delivered on m_
module stream_upsize_arb #(
   parameter int T_DATA_WIDTH = 1,
   parameter int N_SRC        = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_SRC*T_DATA_WIDTH-1:0] s_data_i,
   input  logic [N_SRC-1:0]              s_last_i,
   input  logic [N_SRC-1:0]              s_valid_i,
   output logic [N_SRC-1:0]              s_ready_o,
   output logic [T_DATA_WIDTH-1:0]       m_data_o,
   output logic                          m_last_o,
   output logic                          m_valid_o,
   input  logic                          m_ready_i,
   output logic [$clog2(N_SRC)-1:0]      m_id_o,
   output logic [15:0]                   pkt_cnt_o
);

   localparam int ID_W = $clog2(N_SRC);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t                  state_q;
   logic [ID_W-1:0]         grant_q;
   logic [ID_W-1:0]         rr_ptr_q;
   logic [ID_W-1:0]         pick;
   logic [ID_W-1:0]         nxt_ptr;
   logic [15:0]             pkt_cnt_q;
   logic                    any_req;
   logic                    busy;
   logic                    out_free;
   logic                    acc;
   logic                    g_valid;
   logic                    g_last;
   logic [T_DATA_WIDTH-1:0] g_data;
   int                      idx;

   assign busy     = (state_q == BUSY);
   assign out_free = !m_valid_o || m_ready_i;
   assign any_req  = |s_valid_i;

   assign g_valid = s_valid_i[grant_q];
   assign g_last  = s_last_i[grant_q];
   assign g_data  = s_data_i[int'(grant_q)*T_DATA_WIDTH +: T_DATA_WIDTH];

   assign acc = busy && g_valid && out_free;

   assign nxt_ptr = (grant_q == ID_W'(N_SRC - 1)) ? '0 : grant_q + 1'b1;

   assign pkt_cnt_o = pkt_cnt_q;

   // Walk the ring downward from the farthest slot so the request
   // closest to rr_ptr (searching upward with wrap) is the last writer.
   always_comb begin
      pick = rr_ptr_q;
      idx  = 0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= N_SRC) idx = idx - N_SRC;
         if (s_valid_i[idx[ID_W-1:0]]) pick = idx[ID_W-1:0];
      end
   end

   // Ready follows the output slot directly so a drained slot can
   // refill on the same cycle; only the granted source is ever offered.
   always_comb begin
      s_ready_o = '0;
      if (busy) s_ready_o[grant_q] = out_free;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (any_req) begin
                  grant_q <= pick;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               // A stalled source keeps the grant; only its last beat
               // releases the bus.
               if (acc && g_last) begin
                  state_q  <= IDLE;
                  rr_ptr_q <= nxt_ptr;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_o <= 1'b0;
         m_data_o  <= '0;
         m_last_o  <= 1'b0;
         m_id_o    <= '0;
      end else if (acc) begin
         m_valid_o <= 1'b1;
         m_data_o  <= g_data;
         m_last_o  <= g_last;
         m_id_o    <= grant_q;
      end else if (m_ready_i) begin
         m_valid_o <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt_q <= '0;
      end else if (m_valid_o && m_ready_i && m_last_o) begin
         pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_stream_upsize_arb.sv
// tb_stream_upsize_arb: directed self-checking bench for stream_upsize_arb
// (T_DATA_WIDTH=8, N_SRC=4) with per-source beat lists and an output log.
module tb_stream_upsize_arb;

   localparam int W = 8;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N*W-1:0] s_data;
   logic [N-1:0]   s_last;
   logic [N-1:0]   s_valid;
   logic [N-1:0]   s_ready;
   logic [W-1:0]   m_data;
   logic           m_last;
   logic           m_valid;
   logic           m_ready;
   logic [1:0]     m_id;
   logic [15:0]    pkt_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [8:0]   sb [N][16];
   int           hd [N];
   int           tl [N];
   logic [N-1:0] hold;
   logic [N-1:0] hs;

   logic [7:0] lg_d  [64];
   logic [1:0] lg_id [64];
   logic       lg_l  [64];
   int         lg_c  [64];
   int         lg_n;

   stream_upsize_arb #(
      .T_DATA_WIDTH(W),
      .N_SRC       (N)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_data_i (s_data),
      .s_last_i (s_last),
      .s_valid_i(s_valid),
      .s_ready_o(s_ready),
      .m_data_o (m_data),
      .m_last_o (m_last),
      .m_valid_o(m_valid),
      .m_ready_i(m_ready),
      .m_id_o   (m_id),
      .pkt_cnt_o(pkt_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1 && lg_n < 64) begin
         lg_d[lg_n]  = m_data;
         lg_id[lg_n] = m_id;
         lg_l[lg_n]  = m_last;
         lg_c[lg_n]  = cyc;
         lg_n++;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic refresh();
      for (int i = 0; i < N; i++) begin
         if (hd[i] < tl[i] && !hold[i]) begin
            s_valid[i]       = 1'b1;
            s_data[i*W +: W] = sb[i][hd[i]][7:0];
            s_last[i]        = sb[i][hd[i]][8];
         end else begin
            s_valid[i]       = 1'b0;
            s_data[i*W +: W] = '0;
            s_last[i]        = 1'b0;
         end
      end
   endtask

   task automatic push(input int s, input logic [7:0] d, input logic l);
      sb[s][tl[s]] = {l, d};
      tl[s]++;
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) begin
         hd[i] = 0;
         tl[i] = 0;
      end
      hold = '0;
      lg_n = 0;
      refresh();
   endtask

   function automatic bit pending();
      bit p;
      p = 1'b0;
      for (int i = 0; i < N; i++) if (hd[i] < tl[i]) p = 1'b1;
      return p;
   endfunction

   task automatic tick();
      @(negedge clk);
      hs = s_valid & s_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n) begin
         for (int i = 0; i < N; i++) if (hs[i]) hd[i]++;
      end
      refresh();
      #1;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      m_ready = 1'b1;
      clear_all();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((pending() || m_valid) && n < budget) begin
         tick();
         n++;
      end
      total++;
      if (pending() || m_valid) begin
         bad++;
         $display("FAIL drain: traffic still pending after %0d cycles", budget);
      end
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      m_ready = 1'b1;
      clear_all();
      push(1, 8'h5A, 1'b1);
      refresh();
      #1;
      total++;
      if ({m_valid, m_last, m_data, m_id} !== 12'h000) begin
         bad++;
         $display("FAIL reset_out: got %h want 000", {m_valid, m_last, m_data, m_id});
      end
      total++;
      if (pkt_cnt !== 16'h0000) begin
         bad++;
         $display("FAIL reset_cnt: got %h want 0000", pkt_cnt);
      end
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (s_ready !== 4'b0000) begin
         bad++;
         $display("FAIL reset_noready: got %b want 0000", s_ready);
      end
      rst_n = 1'b1;
      #1;
      total++;
      if (s_ready !== 4'b0000) begin
         bad++;
         $display("FAIL idle_ready: got %b want 0000", s_ready);
      end
      tick();
      total++;
      if (s_ready !== 4'b0010) begin
         bad++;
         $display("FAIL first_grant: got %b want 0010", s_ready);
      end
      tick();
      total++;
      if ({m_valid, m_last, m_id, m_data} !== {1'b1, 1'b1, 2'd1, 8'h5A}) begin
         bad++;
         $display("FAIL single_beat: got %h want %h",
                  {m_valid, m_last, m_id, m_data}, {1'b1, 1'b1, 2'd1, 8'h5A});
      end
      tick();
      total++;
      if (pkt_cnt !== 16'd1 || m_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_cnt: got cnt=%h v=%b want cnt=0001 v=0", pkt_cnt, m_valid);
      end
   endtask

   task automatic test_single_src();
      logic [7:0] ed [3];
      logic       el [3];
      ed = '{8'h11, 8'h22, 8'h33};
      el = '{1'b0, 1'b0, 1'b1};
      do_reset();
      push(2, 8'h11, 1'b0);
      push(2, 8'h22, 1'b0);
      push(2, 8'h33, 1'b1);
      refresh();
      tick();
      for (int k = 0; k < 3; k++) begin
         tick();
         total++;
         if ({m_valid, m_id, m_last, m_data} !== {1'b1, 2'd2, el[k], ed[k]}) begin
            bad++;
            $display("FAIL src2_beat%0d: got %h want %h", k,
                     {m_valid, m_id, m_last, m_data}, {1'b1, 2'd2, el[k], ed[k]});
         end
      end
      total++;
      if (pkt_cnt !== 16'd0) begin
         bad++;
         $display("FAIL src2_early_cnt: got %h want 0000", pkt_cnt);
      end
      tick();
      total++;
      if (pkt_cnt !== 16'd1 || m_valid !== 1'b0) begin
         bad++;
         $display("FAIL src2_cnt: got cnt=%h v=%b want cnt=0001 v=0", pkt_cnt, m_valid);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] eid [10];
      logic [7:0] ed  [10];
      eid = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
      ed  = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03};
      do_reset();
      for (int i = 0; i < N; i++) begin
         push(i, 8'(i * 16), 1'b0);
         push(i, 8'(i * 16 + 1), 1'b1);
      end
      push(0, 8'h02, 1'b0);
      push(0, 8'h03, 1'b1);
      refresh();
      drain(100);
      total++;
      if (lg_n !== 10) begin
         bad++;
         $display("FAIL rr_count: got %0d want 10", lg_n);
      end
      for (int k = 0; k < 10 && k < lg_n; k++) begin
         total++;
         if ({lg_id[k], lg_l[k], lg_d[k]} !== {eid[k], 1'(k % 2), ed[k]}) begin
            bad++;
            $display("FAIL rr_beat%0d: got %h want %h", k,
                     {lg_id[k], lg_l[k], lg_d[k]}, {eid[k], 1'(k % 2), ed[k]});
         end
         if (k > 0) begin
            total++;
            if (lg_c[k] - lg_c[k-1] !== ((k % 2) ? 1 : 2)) begin
               bad++;
               $display("FAIL rr_gap%0d: got %0d want %0d", k,
                        lg_c[k] - lg_c[k-1], (k % 2) ? 1 : 2);
            end
         end
      end
      total++;
      if (pkt_cnt !== 16'd5) begin
         bad++;
         $display("FAIL rr_cnt: got %0d want 5", pkt_cnt);
      end
   endtask

   task automatic test_stall();
      int         n;
      logic [7:0] ed [3];
      ed = '{8'hA1, 8'hB2, 8'hC3};
      do_reset();
      push(1, 8'hA1, 1'b0);
      push(1, 8'hB2, 1'b0);
      push(1, 8'hC3, 1'b1);
      refresh();
      n = 0;
      while (!m_valid && n < 10) begin
         tick();
         n++;
      end
      total++;
      if (m_valid !== 1'b1) begin
         bad++;
         $display("FAIL stall_start: got v=%b want v=1", m_valid);
      end
      m_ready = 1'b0;
      #1;
      for (int c = 0; c < 4; c++) begin
         total++;
         if ({m_valid, m_id, m_last, m_data, s_ready[1]} !==
             {1'b1, 2'd1, 1'b0, 8'hA1, 1'b0}) begin
            bad++;
            $display("FAIL stall_hold%0d: got %h want %h", c,
                     {m_valid, m_id, m_last, m_data, s_ready[1]},
                     {1'b1, 2'd1, 1'b0, 8'hA1, 1'b0});
         end
         tick();
      end
      m_ready = 1'b1;
      #1;
      drain(50);
      total++;
      if (lg_n !== 3) begin
         bad++;
         $display("FAIL stall_count: got %0d want 3", lg_n);
      end
      for (int k = 0; k < 3 && k < lg_n; k++) begin
         total++;
         if ({lg_id[k], lg_l[k], lg_d[k]} !== {2'd1, k == 2, ed[k]}) begin
            bad++;
            $display("FAIL stall_beat%0d: got %h want %h", k,
                     {lg_id[k], lg_l[k], lg_d[k]}, {2'd1, k == 2, ed[k]});
         end
      end
   endtask

   task automatic test_hold_grant();
      int         n;
      logic [1:0] eid [4];
      logic [7:0] ed  [4];
      logic       el  [4];
      eid = '{2'd0, 2'd0, 2'd0, 2'd3};
      ed  = '{8'h0A, 8'h0B, 8'h0C, 8'h3D};
      el  = '{1'b0, 1'b0, 1'b1, 1'b1};
      do_reset();
      push(0, 8'h0A, 1'b0);
      push(0, 8'h0B, 1'b0);
      push(0, 8'h0C, 1'b1);
      push(3, 8'h3D, 1'b1);
      refresh();
      n = 0;
      while (hd[0] < 1 && n < 10) begin
         tick();
         n++;
      end
      total++;
      if (hd[0] !== 1) begin
         bad++;
         $display("FAIL hold_start: got %0d beats want 1", hd[0]);
      end
      hold[0] = 1'b1;
      refresh();
      #1;
      for (int c = 0; c < 5; c++) begin
         total++;
         if (s_ready[3] !== 1'b0) begin
            bad++;
            $display("FAIL hold_src3_ready%0d: got %b want 0", c, s_ready[3]);
         end
         tick();
      end
      hold[0] = 1'b0;
      refresh();
      #1;
      drain(50);
      total++;
      if (lg_n !== 4) begin
         bad++;
         $display("FAIL hold_count: got %0d want 4", lg_n);
      end
      for (int k = 0; k < 4 && k < lg_n; k++) begin
         total++;
         if ({lg_id[k], lg_l[k], lg_d[k]} !== {eid[k], el[k], ed[k]}) begin
            bad++;
            $display("FAIL hold_beat%0d: got %h want %h", k,
                     {lg_id[k], lg_l[k], lg_d[k]}, {eid[k], el[k], ed[k]});
         end
      end
      if (lg_n > 1) begin
         total++;
         if (lg_c[1] - lg_c[0] !== 6) begin
            bad++;
            $display("FAIL hold_gap: got %0d want 6", lg_c[1] - lg_c[0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset();
      for (int b = 0; b < 4; b++) push(2, 8'(8'h40 + b), b == 3);
      refresh();
      n = 0;
      while (hd[2] < 1 && n < 10) begin
         tick();
         n++;
      end
      total++;
      if (m_valid !== 1'b1 || m_id !== 2'd2) begin
         bad++;
         $display("FAIL rstmid_start: got v=%b id=%0d want v=1 id=2", m_valid, m_id);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({m_valid, m_last, m_data, m_id, s_ready, pkt_cnt} !== 32'h0) begin
         bad++;
         $display("FAIL rstmid_outs: got %h want 00000000",
                  {m_valid, m_last, m_data, m_id, s_ready, pkt_cnt});
      end
      clear_all();
      push(1, 8'h51, 1'b1);
      push(2, 8'h52, 1'b1);
      refresh();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      drain(50);
      total++;
      if (lg_n !== 2) begin
         bad++;
         $display("FAIL rstmid_count: got %0d want 2", lg_n);
      end
      if (lg_n > 1) begin
         total++;
         if ({lg_id[0], lg_d[0], lg_id[1], lg_d[1]} !== {2'd1, 8'h51, 2'd2, 8'h52}) begin
            bad++;
            $display("FAIL rstmid_order: got %h want %h",
                     {lg_id[0], lg_d[0], lg_id[1], lg_d[1]}, {2'd1, 8'h51, 2'd2, 8'h52});
         end
      end
   endtask

   task automatic test_pkt_wrap();
      logic [15:0] prev;
      logic [15:0] seen [4];
      logic [15:0] ev   [3];
      int          nchg;
      ev = '{16'hFFFF, 16'h0000, 16'h0001};
      do_reset();
      force dut.pkt_cnt_q = 16'hFFFE;
      @(posedge clk);
      #1;
      release dut.pkt_cnt_q;
      #1;
      total++;
      if (pkt_cnt !== 16'hFFFE) begin
         bad++;
         $display("FAIL wrap_preload: got %h want FFFE", pkt_cnt);
      end
      push(0, 8'hE0, 1'b1);
      push(1, 8'hE1, 1'b1);
      push(2, 8'hE2, 1'b1);
      refresh();
      prev = pkt_cnt;
      nchg = 0;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (pkt_cnt !== prev) begin
            if (nchg < 4) seen[nchg] = pkt_cnt;
            nchg++;
            prev = pkt_cnt;
         end
      end
      total++;
      if (nchg !== 3) begin
         bad++;
         $display("FAIL wrap_steps: got %0d want 3", nchg);
      end
      for (int k = 0; k < 3 && k < nchg; k++) begin
         total++;
         if (seen[k] !== ev[k]) begin
            bad++;
            $display("FAIL wrap_val%0d: got %h want %h", k, seen[k], ev[k]);
         end
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      m_ready = 1'b1;
      s_data  = '0;
      s_last  = '0;
      s_valid = '0;
      hold    = '0;
      lg_n    = 0;
      test_reset();
      test_single_src();
      test_round_robin();
      test_stall();
      test_hold_grant();
      test_reset_mid();
      test_pkt_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
